// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loadable instruction memory.
package imem_pkg;

   // Controller states: normal fetch service, or bootloading the array.
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } imem_state_e;

   // Default word returned for out-of-range fetches.
   localparam logic [15:0] NOP_DEFAULT = 16'h0000;

   // Supported fetch latency window.
   localparam int unsigned RD_LAT_MIN = 32'd1;
   localparam int unsigned RD_LAT_MAX = 32'd3;

   // True when a requested fetch latency is supported by the read pipe.
   function automatic logic rd_lat_legal(input int unsigned lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// Fixed-depth delay line for fetch results: carries {data, vld, err}.
// The data registers only load valid words, so the final stage holds the
// last delivered instruction while no new result arrives. A squash empties
// every stage at once without disturbing the held data.
module imem_rd_pipe #(
   parameter int unsigned DATA_W = 32'd16,
   parameter int unsigned RD_LAT = 32'd1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              squash_i,
   input  logic              in_vld_i,
   input  logic              in_err_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_vld_o,
   output logic              out_err_o,
   output logic [DATA_W-1:0] out_data_o
);

   logic [DATA_W-1:0] data_q    [RD_LAT];
   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] err_q;

   logic [DATA_W-1:0] data_in_s [RD_LAT];
   logic [RD_LAT-1:0] vld_in_s;
   logic [RD_LAT-1:0] err_in_s;

   // Stage inputs: stage 0 takes the new fetch, later stages take their predecessor.
   always_comb begin
      vld_in_s     = '0;
      err_in_s     = '0;
      vld_in_s[0]  = in_vld_i;
      err_in_s[0]  = in_err_i;
      data_in_s[0] = in_data_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         vld_in_s[i]  = vld_q[i-1];
         err_in_s[i]  = err_q[i-1];
         data_in_s[i] = data_q[i-1];
      end
   end

   // Advance the delay line; squash clears all valids, data loads only with a valid word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) begin
            data_q[i] <= '0;
         end
      end else if (squash_i) begin
         vld_q <= '0;
         err_q <= '0;
      end else begin
         vld_q <= vld_in_s;
         err_q <= err_in_s & vld_in_s;
         for (int i = 0; i < int'(RD_LAT); i++) begin
            if (vld_in_s[i]) begin
               data_q[i] <= data_in_s[i];
            end
         end
      end
   end

   assign out_vld_o  = vld_q[RD_LAT-1];
   assign out_err_o  = err_q[RD_LAT-1];
   assign out_data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/imem_boot_fetch.sv
// Parametrised instruction memory with a valid-qualified fetch port, an
// out-of-range fault flag and a valid/ready bootloader that fills the array
// at run time. The controller is RUN (serving fetches) or LOAD (accepting
// loader words); entering LOAD squashes every fetch still in flight.
module imem_boot_fetch
   import imem_pkg::*;
#(
   parameter int unsigned       DATA_W    = 32'd16,
   parameter int unsigned       ADDR_W    = 32'd16,
   parameter int unsigned       DEPTH     = 32'd65536,
   parameter int unsigned       RD_LAT    = 32'd1,
   parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_DEFAULT),
   parameter string             INIT_FILE = ""
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] instr_o,
   output logic              instr_vld_o,
   output logic              addr_err_o,
   input  logic              load_start_i,
   input  logic              ld_valid_i,
   input  logic [DATA_W-1:0] ld_data_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              load_done_o,
   output logic              busy_o
);

   // Array index width; pointer and fetch address keep the full ADDR_W for range checks.
   localparam int unsigned       IDX_W    = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
   // DEPTH widened by one bit so DEPTH == 2**ADDR_W stays representable.
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 32'd1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   imem_state_e       state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              ld_ready_q;
   logic              load_done_q;
   logic              busy_q;

   logic              in_run_s;
   logic              squash_s;
   logic              rd_go_s;
   logic              oor_s;
   logic              wr_en_s;
   logic              wr_exit_s;
   logic [DATA_W-1:0] rd_word_s;

   generate
      if (!rd_lat_legal(RD_LAT) || (64'(DEPTH) > (64'd1 << ADDR_W)) || (DEPTH < 32'd2)) begin : g_bad_cfg
         $error("imem_boot_fetch: illegal RD_LAT/DEPTH/ADDR_W combination");
      end
   endgenerate

   // Decode fetch issue, squash, range fault and loader write/exit for this cycle.
   always_comb begin
      in_run_s  = (state_q == ST_RUN);
      squash_s  = in_run_s & load_start_i;
      rd_go_s   = in_run_s & rd_en_i & ~load_start_i;
      oor_s     = ({1'b0, addr_i} >= DEPTH_X);
      wr_en_s   = (state_q == ST_LOAD) & ld_valid_i & ld_ready_q;
      wr_exit_s = wr_en_s & (ld_last_i | (ptr_q == LAST_PTR));
      if (rd_go_s && !oor_s) begin
         rd_word_s = mem_q[addr_i[IDX_W-1:0]];
      end else begin
         rd_word_s = NOP_WORD;
      end
   end

   // Run/load controller: owns the load pointer and the registered handshake/status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         ptr_q       <= '0;
         ld_ready_q  <= 1'b0;
         load_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (load_start_i) begin
                  state_q    <= ST_LOAD;
                  ptr_q      <= '0;
                  ld_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (wr_exit_s) begin
                  state_q     <= ST_RUN;
                  ld_ready_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  load_done_q <= 1'b1;
               end else if (wr_en_s) begin
                  ptr_q <= ptr_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q    <= ST_RUN;
               ld_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   // Loader write port; the array has no reset so loaded words survive a reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_q[ptr_q[IDX_W-1:0]] <= ld_data_i;
      end
   end

   imem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .squash_i   (squash_s),
      .in_vld_i   (rd_go_s),
      .in_err_i   (oor_s),
      .in_data_i  (rd_word_s),
      .out_vld_o  (instr_vld_o),
      .out_err_o  (addr_err_o),
      .out_data_o (instr_o)
   );

   assign ld_ready_o  = ld_ready_q;
   assign load_done_o = load_done_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_imem_boot_fetch.sv
// Bench for imem_boot_fetch: three configurations share one stimulus stream
// and are compared every cycle against a queue-based behavioural model.
//   inst 0: RD_LAT=1, DEPTH=256, ADDR_W=16
//   inst 1: RD_LAT=3, DEPTH=200, ADDR_W=16
//   inst 2: RD_LAT=2, DEPTH=256, ADDR_W=8  (DEPTH == 2**ADDR_W)
module tb_imem_boot_fetch;

   localparam logic [15:0] NOP = 16'hBEEF;
   localparam int LAT   [3] = '{1, 3, 2};
   localparam int DEP   [3] = '{256, 200, 256};
   localparam int AMASK [3] = '{32'hFFFF, 32'hFFFF, 32'h00FF};

   logic        clk;
   logic        rst;
   logic        rd_en;
   logic [15:0] addr;
   logic        load_start;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_last;

   logic [15:0] instr_w [3];
   logic        vld_w   [3];
   logic        err_w   [3];
   logic        rdy_w   [3];
   logic        done_w  [3];
   logic        busy_w  [3];

   int n_checks = 0;
   int n_pass   = 0;

   imem_boot_fetch #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1), .NOP_WORD(NOP), .INIT_FILE("")) u_a (
      .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .addr_i(addr),
      .instr_o(instr_w[0]), .instr_vld_o(vld_w[0]), .addr_err_o(err_w[0]),
      .load_start_i(load_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
      .ld_ready_o(rdy_w[0]), .load_done_o(done_w[0]), .busy_o(busy_w[0]));

   imem_boot_fetch #(.DATA_W(16), .ADDR_W(16), .DEPTH(200), .RD_LAT(3), .NOP_WORD(NOP), .INIT_FILE("")) u_b (
      .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .addr_i(addr),
      .instr_o(instr_w[1]), .instr_vld_o(vld_w[1]), .addr_err_o(err_w[1]),
      .load_start_i(load_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
      .ld_ready_o(rdy_w[1]), .load_done_o(done_w[1]), .busy_o(busy_w[1]));

   imem_boot_fetch #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(2), .NOP_WORD(NOP), .INIT_FILE("")) u_c (
      .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .addr_i(addr[7:0]),
      .instr_o(instr_w[2]), .instr_vld_o(vld_w[2]), .addr_err_o(err_w[2]),
      .load_start_i(load_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
      .ld_ready_o(rdy_w[2]), .load_done_o(done_w[2]), .busy_o(busy_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int          left;
      logic [15:0] data;
      bit          err;
      bit          known;
   } fetch_t;

   fetch_t      pq      [3][$];
   bit          m_load  [3];
   int          m_ptr   [3];
   logic [15:0] m_mem   [3][256];
   bit          m_known [3][256];
   logic [15:0] e_instr [3];
   bit          e_ikn   [3];
   bit          e_vld   [3];
   bit          e_err   [3];
   bit          e_done  [3];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_load[k]  = 1'b0;
         m_ptr[k]   = 0;
         pq[k].delete();
         e_instr[k] = 16'h0000;
         e_ikn[k]   = 1'b1;
         e_vld[k]   = 1'b0;
         e_err[k]   = 1'b0;
         e_done[k]  = 1'b0;
      end
   endtask

   // One rising edge for instance k, using the currently driven inputs.
   task automatic model_step(input int k);
      fetch_t f;
      int     a;
      e_vld[k]  = 1'b0;
      e_err[k]  = 1'b0;
      e_done[k] = 1'b0;
      if (!m_load[k]) begin
         if (load_start) begin
            m_load[k] = 1'b1;
            m_ptr[k]  = 0;
            pq[k].delete();
         end else begin
            if (rd_en) begin
               a      = int'(addr) & AMASK[k];
               f.left = LAT[k];
               f.err  = (a >= DEP[k]);
               if (f.err) begin
                  f.data  = NOP;
                  f.known = 1'b1;
               end else begin
                  f.data  = m_mem[k][a];
                  f.known = m_known[k][a];
               end
               pq[k].push_back(f);
            end
            for (int i = 0; i < pq[k].size(); i++) begin
               f = pq[k][i];
               f.left--;
               pq[k][i] = f;
            end
            if (pq[k].size() > 0 && pq[k][0].left == 0) begin
               f = pq[k].pop_front();
               e_vld[k]   = 1'b1;
               e_err[k]   = f.err;
               e_instr[k] = f.data;
               e_ikn[k]   = f.known;
            end
         end
      end else if (ld_valid) begin
         m_mem[k][m_ptr[k]]   = ld_data;
         m_known[k][m_ptr[k]] = 1'b1;
         if (ld_last || m_ptr[k] == DEP[k] - 1) begin
            m_load[k] = 1'b0;
            e_done[k] = 1'b1;
         end else begin
            m_ptr[k]++;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("instr_vld[%0d]", k), 32'(vld_w[k]),  32'(e_vld[k]));
         check_eq($sformatf("addr_err[%0d]", k),  32'(err_w[k]),  32'(e_err[k]));
         check_eq($sformatf("busy[%0d]", k),      32'(busy_w[k]), 32'(m_load[k]));
         check_eq($sformatf("ld_ready[%0d]", k),  32'(rdy_w[k]),  32'(m_load[k]));
         check_eq($sformatf("load_done[%0d]", k), 32'(done_w[k]), 32'(e_done[k]));
         if (e_ikn[k]) begin
            check_eq($sformatf("instr[%0d]", k), 32'(instr_w[k]), 32'(e_instr[k]));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic drive(input bit re, input logic [15:0] a, input bit ls,
                        input bit lv, input logic [15:0] ld, input bit ll);
      rd_en      = re;
      addr       = a;
      load_start = ls;
      ld_valid   = lv;
      ld_data    = ld;
      ld_last    = ll;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < 3; k++) model_step(k);
      end
      @(negedge clk);
      check_all();
   endtask

   function automatic bit any_loading();
      return m_load[0] | m_load[1] | m_load[2];
   endfunction

   initial begin
      int bound;
      logic [15:0] w0;
      logic [15:0] w1;

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 256; i++) m_known[k][i] = 1'b0;
      end
      rst = 1'b1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      repeat (2) @(negedge clk);
      model_reset();
      check_all();
      rst = 1'b0;
      cyc();

      // Bootload three words with valid gaps, last flagged on the third.
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hA000, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0); cyc(); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hA001, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hA002, 1'b1); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();

      // Back-to-back fetches, then rd_en drops and instr must hold.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      end
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      repeat (4) cyc();

      // Out-of-range and boundary addresses.
      drive(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b1, 16'h00C8, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b1, 16'h00C7, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      repeat (4) cyc();

      // Squash: fetch at N, load_start (with a dropped fetch) at N+1.
      drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, w0, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, w1, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();

      // Reset mid-load: asserted between edges, no load_done afterwards.
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      cyc();
      rst = 1'b0;
      cyc();
      drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      repeat (4) cyc();

      // Full load without ld_last: exit forced at pointer DEPTH-1.
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0); cyc();
      bound = 0;
      while (any_loading() && bound < 400) begin
         drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hC000 + 16'(bound), 1'b0);
         cyc();
         bound++;
      end
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0); cyc();
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("forced_exit_busy[%0d]", k), 32'(busy_w[k]), 32'd0);
      end

      // Randomized mix of fetches, loads, squashes and stalls.
      for (int n = 0; n < 800; n++) begin
         logic [15:0] a;
         case ($urandom_range(3, 0))
            0, 1:    a = 16'($urandom_range(255, 0));
            2:       a = 16'($urandom_range(270, 190));
            default: a = 16'($urandom);
         endcase
         drive(($urandom_range(3, 0) != 0), a, ($urandom_range(39, 0) == 0),
               ($urandom_range(2, 0) != 0), 16'($urandom), ($urandom_range(7, 0) == 0));
         cyc();
      end

      // Drain any open load, then idle.
      bound = 0;
      while (any_loading() && bound < 20) begin
         drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5555, 1'b1);
         cyc();
         bound++;
      end
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      repeat (5) cyc();
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("final_busy[%0d]", k), 32'(busy_w[k]), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
